// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Two BCD banks, frame-aligned source switching, dead time, leading-zero blanking and blink.
module seg7_scan_ctrl #(
    parameter int NDIG         = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*NDIG-1:0]   data_a,
    input  logic [4*NDIG-1:0]   data_b,
    input  logic                sel_req,
    output logic                sel_ack,
    input  logic                lz_sup,
    input  logic                blink,
    output logic [7:0]          seg_out,
    output logic [NDIG-1:0]     dig_en_n,
    output logic                frame_done
);

    localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NDIG - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        logic [7:0] s;
        case (bcd)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1B;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h19;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [IDX_W-1:0]  idx_q,  idx_d;
    logic [4*NDIG-1:0] snap_q, snap_d;
    logic              sel_ack_q, sel_ack_d;
    logic              phase_q, phase_d;
    logic              disp_on_q, disp_on_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]        seg_q, seg_d;
    logic [NDIG-1:0]   dig_q, dig_d;
    logic              frame_done_q, frame_done_d;

    logic              frame_start, frame_end, blank_all;
    logic              upper_zero, cur_lz;
    logic [3:0]        cur_digit;

    always_comb begin
        frame_start = (cnt_q == '0) && (idx_q == '0);
        frame_end   = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        snap_d    = snap_q;
        sel_ack_d = sel_ack_q;
        disp_on_d = disp_on_q;
        if (frame_start) begin
            snap_d    = sel_req ? data_b : data_a;
            sel_ack_d = sel_req;
            disp_on_d = !blink || phase_q;
        end

        // Blink phase runs freely; it is only latched into disp_on at frame start.
        phase_d = phase_q;
        fcnt_d  = fcnt_q;
        if (!blink) begin
            phase_d = 1'b1;
            fcnt_d  = '0;
        end else if (frame_end) begin
            if (fcnt_q == FCNT_MAX) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Outputs are computed from next state so the registered pins line up with cnt_q/idx_q.
    always_comb begin
        upper_zero = 1'b1;
        cur_lz     = 1'b0;
        cur_digit  = 4'd0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (snap_d[4*i +: 4] == 4'd0);
            if (idx_d == IDX_W'(i)) begin
                cur_digit = snap_d[4*i +: 4];
                cur_lz    = upper_zero && (i != 0);
            end
        end

        blank_all    = (cnt_d == '0) || !disp_on_d;
        seg_d        = (blank_all || (lz_sup && cur_lz)) ? 8'hFF : seg_decode(cur_digit);
        dig_d        = blank_all ? '1 : ~(NDIG'(1) << idx_d);
        frame_done_d = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            sel_ack_q    <= 1'b0;
            phase_q      <= 1'b1;
            disp_on_q    <= 1'b1;
            fcnt_q       <= '0;
            seg_q        <= 8'hFF;
            dig_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            sel_ack_q    <= sel_ack_d;
            phase_q      <= phase_d;
            disp_on_q    <= disp_on_d;
            fcnt_q       <= fcnt_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_en_n   = dig_q;
    assign sel_ack    = sel_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, PRESCALE=4, BLINK_FRAMES=2.
module tb_seg7_scan_ctrl;

    localparam int NDIG = 4;
    localparam int PRESCALE = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_a, data_b;
    logic        sel_req, lz_sup, blink;
    logic        sel_ack, frame_done;
    logic [7:0]  seg_out;
    logic [3:0]  dig_en_n;

    int checks = 0;
    int failures = 0;

    seg7_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
        .sel_req(sel_req), .sel_ack(sel_ack), .lz_sup(lz_sup), .blink(blink),
        .seg_out(seg_out), .dig_en_n(dig_en_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; data_a = 16'h1234; data_b = 16'h0987;
        sel_req = 1'b0; lz_sup = 1'b0; blink = 1'b0;
        step(); step();
        checks++; if (seg_out !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=ff", seg_out); end
        checks++; if (dig_en_n !== 4'hF) begin failures++; $display("FAIL reset_dig got=%b exp=1111", dig_en_n); end
        checks++; if (sel_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", sel_ack); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    endtask

    // Entered in the first (dead) cycle after reset; leaves aligned on the last cycle of a frame.
    task automatic test_basic_scan();
        logic [7:0] tbl [4];
        logic [3:0] e_dig; logic [7:0] e_seg; int cnt, idx;
        tbl = '{8'h99, 8'h0D, 8'h25, 8'h9F};
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) step();
            cnt = c % 4; idx = c / 4;
            e_dig = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
            e_seg = (cnt == 0) ? 8'hFF : tbl[idx];
            checks++; if (seg_out !== e_seg) begin failures++; $display("FAIL scan_seg c=%0d got=%h exp=%h", c, seg_out, e_seg); end
            checks++; if (dig_en_n !== e_dig) begin failures++; $display("FAIL scan_dig c=%0d got=%b exp=%b", c, dig_en_n, e_dig); end
            checks++; if (frame_done !== (c == 15)) begin failures++; $display("FAIL scan_fd c=%0d got=%b exp=%b", c, frame_done, c == 15); end
        end
    endtask

    task automatic test_sel_switch();
        logic [7:0] tbl [2][4];
        logic [3:0] e_dig; logic [7:0] e_seg; logic e_ack; int cnt, idx;
        tbl = '{'{8'h99, 8'h0D, 8'h25, 8'h9F}, '{8'h1B, 8'h01, 8'h19, 8'h03}};
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 16; c++) begin
                step();
                cnt = c % 4; idx = c / 4;
                e_dig = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
                e_seg = (cnt == 0) ? 8'hFF : tbl[f][idx];
                e_ack = (f == 1) && (c >= 1);
                checks++; if (seg_out !== e_seg) begin failures++; $display("FAIL sel_seg f=%0d c=%0d got=%h exp=%h", f, c, seg_out, e_seg); end
                checks++; if (dig_en_n !== e_dig) begin failures++; $display("FAIL sel_dig f=%0d c=%0d got=%b exp=%b", f, c, dig_en_n, e_dig); end
                checks++; if (sel_ack !== e_ack) begin failures++; $display("FAIL sel_ack f=%0d c=%0d got=%b exp=%b", f, c, sel_ack, e_ack); end
                if (f == 0 && c == 5) sel_req = 1'b1;
            end
        end
    endtask

    task automatic test_lz_suppress();
        logic [7:0] tbl [2][4];
        logic [3:0] e_dig; logic [7:0] e_seg; int cnt, idx;
        tbl = '{'{8'h03, 8'h49, 8'hFF, 8'hFF}, '{8'h03, 8'hFF, 8'hFF, 8'hFF}};
        sel_req = 1'b0; lz_sup = 1'b1; data_a = 16'h0050;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 16; c++) begin
                step();
                cnt = c % 4; idx = c / 4;
                e_dig = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
                e_seg = (cnt == 0) ? 8'hFF : tbl[f][idx];
                checks++; if (seg_out !== e_seg) begin failures++; $display("FAIL lz_seg f=%0d c=%0d got=%h exp=%h", f, c, seg_out, e_seg); end
                checks++; if (dig_en_n !== e_dig) begin failures++; $display("FAIL lz_dig f=%0d c=%0d got=%b exp=%b", f, c, dig_en_n, e_dig); end
                if (f == 0 && c == 15) data_a = 16'h0000;
                if (f == 1 && c == 6) data_a = 16'h5678;
            end
        end
        lz_sup = 1'b0;
    endtask

    task automatic test_non_bcd();
        logic [7:0] tbl [4];
        logic [3:0] e_dig; logic [7:0] e_seg; int cnt, idx;
        tbl = '{8'hFF, 8'hFF, 8'h03, 8'h03};
        data_a = 16'h00AF;
        for (int c = 0; c < 16; c++) begin
            step();
            cnt = c % 4; idx = c / 4;
            e_dig = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
            e_seg = (cnt == 0) ? 8'hFF : tbl[idx];
            checks++; if (seg_out !== e_seg) begin failures++; $display("FAIL nbcd_seg c=%0d got=%h exp=%h", c, seg_out, e_seg); end
            checks++; if (dig_en_n !== e_dig) begin failures++; $display("FAIL nbcd_dig c=%0d got=%b exp=%b", c, dig_en_n, e_dig); end
        end
    endtask

    task automatic test_blink();
        logic [7:0] tbl [4];
        logic       dark [8];
        logic [3:0] e_dig; logic [7:0] e_seg; int cnt, idx;
        tbl  = '{8'h99, 8'h0D, 8'h25, 8'h9F};
        dark = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        data_a = 16'h1234;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 16; c++) begin
                step();
                cnt = c % 4; idx = c / 4;
                e_dig = (cnt == 0 || dark[f]) ? 4'hF : ~(4'b0001 << idx);
                e_seg = (cnt == 0 || dark[f]) ? 8'hFF : tbl[idx];
                checks++; if (seg_out !== e_seg) begin failures++; $display("FAIL blink_seg f=%0d c=%0d got=%h exp=%h", f, c, seg_out, e_seg); end
                checks++; if (dig_en_n !== e_dig) begin failures++; $display("FAIL blink_dig f=%0d c=%0d got=%b exp=%b", f, c, dig_en_n, e_dig); end
                checks++; if (frame_done !== (c == 15)) begin failures++; $display("FAIL blink_fd f=%0d c=%0d got=%b exp=%b", f, c, frame_done, c == 15); end
                if (f == 0 && c == 0) blink = 1'b1;
                if (f == 6 && c == 6) blink = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] tbl [4];
        logic [7:0] tbl2 [4];
        logic [3:0] e_dig; logic [7:0] e_seg; int cnt, idx;
        tbl  = '{8'h9F, 8'h25, 8'h0D, 8'h99};
        tbl2 = '{8'h01, 8'h1B, 8'h41, 8'h49};
        sel_req = 1'b1; data_b = 16'h4321;
        for (int c = 0; c < 10; c++) begin
            step();
            cnt = c % 4; idx = c / 4;
            e_dig = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
            e_seg = (cnt == 0) ? 8'hFF : tbl[idx];
            checks++; if (seg_out !== e_seg) begin failures++; $display("FAIL rmid_seg c=%0d got=%h exp=%h", c, seg_out, e_seg); end
            checks++; if (dig_en_n !== e_dig) begin failures++; $display("FAIL rmid_dig c=%0d got=%b exp=%b", c, dig_en_n, e_dig); end
            checks++; if (sel_ack !== (c >= 1)) begin failures++; $display("FAIL rmid_ack c=%0d got=%b exp=%b", c, sel_ack, c >= 1); end
        end
        rst = 1'b0; sel_req = 1'b0; data_a = 16'h5678;
        step();
        checks++; if (seg_out !== 8'hFF) begin failures++; $display("FAIL rmid_rst_seg got=%h exp=ff", seg_out); end
        checks++; if (dig_en_n !== 4'hF) begin failures++; $display("FAIL rmid_rst_dig got=%b exp=1111", dig_en_n); end
        checks++; if (sel_ack !== 1'b0) begin failures++; $display("FAIL rmid_rst_ack got=%b exp=0", sel_ack); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rmid_rst_fd got=%b exp=0", frame_done); end
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) step();
            cnt = c % 4; idx = c / 4;
            e_dig = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
            e_seg = (cnt == 0) ? 8'hFF : tbl2[idx];
            checks++; if (seg_out !== e_seg) begin failures++; $display("FAIL rpost_seg c=%0d got=%h exp=%h", c, seg_out, e_seg); end
            checks++; if (dig_en_n !== e_dig) begin failures++; $display("FAIL rpost_dig c=%0d got=%b exp=%b", c, dig_en_n, e_dig); end
            checks++; if (frame_done !== (c == 15)) begin failures++; $display("FAIL rpost_fd c=%0d got=%b exp=%b", c, frame_done, c == 15); end
            checks++; if (sel_ack !== 1'b0) begin failures++; $display("FAIL rpost_ack c=%0d got=%b exp=0", c, sel_ack); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_sel_switch();
        test_lz_suppress();
        test_non_bcd();
        test_blink();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
